stf_gen: RTL

STF_GEN -- requirements
Module: stf_gen

---
 rtl/stf_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stf_gen.sv
// Purpose : 802.11a short-training-field generator, NUM_REP x 16 complex samples per burst.
// Latency : start sampled on edge n -> first sample (t0) presented after edge n; done one cycle after the final accept.
// Backpr. : valid/ready on sample_out; the sample and strobe hold while out_ready is low.
module stf_gen #(
  parameter int NUM_REP = 10,
  parameter bit WINDOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  gain_shift,
  input  logic        out_ready,
  output logic [31:0] sample_out,
  output logic        sample_out_strobe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_REP = 8'(NUM_REP - 1);

  state_t             state;
  logic [3:0]         idx;
  logic [7:0]         rep;
  logic [1:0]         gain_q;

  logic               accept;
  logic               last;
  logic [3:0]         nxt_idx;
  logic [7:0]         nxt_rep;
  logic [1:0]         gain_sel;
  logic [31:0]        raw;
  logic signed [15:0] si;
  logic signed [15:0] sq;
  logic [31:0]        nxt_sample;

  // Short training symbol, time domain, scaled by 8192 and rounded: {I, Q}
  function automatic logic [31:0] stf_rom(input logic [3:0] k);
    logic [31:0] v;
    case (k)
      4'd0:    v = {16'sd377,   16'sd377};
      4'd1:    v = {-16'sd1081, 16'sd16};
      4'd2:    v = {-16'sd106,  -16'sd647};
      4'd3:    v = {16'sd1171,  -16'sd106};
      4'd4:    v = {16'sd754,   16'sd0};
      4'd5:    v = {16'sd1171,  -16'sd106};
      4'd6:    v = {-16'sd106,  -16'sd647};
      4'd7:    v = {-16'sd1081, 16'sd16};
      4'd8:    v = {16'sd377,   16'sd377};
      4'd9:    v = {16'sd16,    -16'sd1081};
      4'd10:   v = {-16'sd647,  -16'sd106};
      4'd11:   v = {-16'sd106,  16'sd1171};
      4'd12:   v = {16'sd0,     16'sd754};
      4'd13:   v = {-16'sd106,  16'sd1171};
      4'd14:   v = {-16'sd647,  -16'sd106};
      default: v = {16'sd16,    -16'sd1081};
    endcase
    return v;
  endfunction

  assign accept = sample_out_strobe & out_ready;
  assign last   = (idx == 4'd15) && (rep == LAST_REP);

  // Pick the position of the sample to present next and shape it (window, then gain)
  always_comb begin
    nxt_idx  = idx;
    nxt_rep  = rep;
    gain_sel = gain_q;
    if (state == IDLE) begin
      nxt_idx  = 4'd0;
      nxt_rep  = 8'd0;
      gain_sel = gain_shift;
    end else if (accept) begin
      nxt_idx = idx + 4'd1;
      if (idx == 4'd15) begin
        nxt_rep = rep + 8'd1;
      end
    end
    raw = stf_rom(nxt_idx);
    si  = raw[31:16];
    sq  = raw[15:0];
    if (WINDOW && (nxt_idx == 4'd0) && (nxt_rep == 8'd0)) begin
      si = si >>> 1;
      sq = sq >>> 1;
    end
    si = si >>> gain_sel;
    sq = sq >>> gain_sel;
    nxt_sample = {si, sq};
  end

  // Burst FSM with registered outputs; abort has priority over everything but enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      idx               <= 4'd0;
      rep               <= 8'd0;
      gain_q            <= 2'd0;
      sample_out        <= 32'd0;
      sample_out_strobe <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else if (!enable) begin
      sample_out        <= 32'd0;
      sample_out_strobe <= 1'b0;
      done              <= 1'b0;
    end else if (abort) begin
      state             <= IDLE;
      idx               <= 4'd0;
      rep               <= 8'd0;
      sample_out        <= 32'd0;
      sample_out_strobe <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state             <= RUN;
            busy              <= 1'b1;
            gain_q            <= gain_shift;
            idx               <= 4'd0;
            rep               <= 8'd0;
            sample_out        <= nxt_sample;
            sample_out_strobe <= 1'b1;
          end
        end
        RUN: begin
          if (accept && last) begin
            state             <= DONE;
            busy              <= 1'b0;
            done              <= 1'b1;
            idx               <= 4'd0;
            rep               <= 8'd0;
            sample_out        <= 32'd0;
            sample_out_strobe <= 1'b0;
          end else begin
            idx               <= nxt_idx;
            rep               <= nxt_rep;
            sample_out        <= nxt_sample;
            sample_out_strobe <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
